// File: rtl/global_ale_estimator_if.sv
`default_nettype none
// ============================================================================
//  Module      : global_ale_estimator_if
//  Description : Pixel-stream input and atmospheric-light output bundle for
//                the global atmospheric-light estimator.
//  Revision    : 1.0  initial release
// ============================================================================
interface global_ale_estimator_if;
  // Pixel stream toward the estimator
  logic       pix_valid;
  logic       pix_sof;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  // Dark channel and global atmospheric light from the estimator
  logic [7:0] dark_out;
  logic       dark_valid;
  logic [7:0] AR_global;
  logic [7:0] AG_global;
  logic [7:0] AB_global;
  logic       a_valid;
  logic       a_update;

  // Pixel source / consumer of A
  modport master (
    output pix_valid, pix_sof, pix_r, pix_g, pix_b,
    input  dark_out, dark_valid, AR_global, AG_global, AB_global, a_valid, a_update
  );

  // Estimator side
  modport slave (
    input  pix_valid, pix_sof, pix_r, pix_g, pix_b,
    output dark_out, dark_valid, AR_global, AG_global, AB_global, a_valid, a_update
  );
endinterface
`default_nettype wire

// File: rtl/global_ale_estimator.sv
`default_nettype none
// ============================================================================
//  Module      : global_ale_estimator
//  Description : Forms the per-pixel dark channel min(R,G,B), tracks the pixel
//                with the largest dark value in each frame and publishes its
//                RGB as the global atmospheric light at end of frame, with
//                optional IIR smoothing across frames.
//  Revision    : 1.0  initial release
// ============================================================================
module global_ale_estimator #(
  parameter int IMG_W     = 4,
  parameter int IMG_H     = 2,
  parameter bit SMOOTH_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  global_ale_estimator_if.slave bus
);

  localparam int C_NPIX  = IMG_W * IMG_H;
  localparam int C_CNT_W = $clog2(C_NPIX + 1);
  localparam logic [C_CNT_W-1:0] C_NPIX_CNT = C_CNT_W'(C_NPIX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  // A one-pixel frame is complete as soon as its sof pixel is taken.
  localparam state_t C_AFTER_SOF = (C_NPIX == 1) ? S_UPDATE : S_ACCUM;

  state_t              state_q, state_d;
  logic [C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]          max_dark_q, max_dark_d;
  logic [7:0]          max_r_q, max_r_d;
  logic [7:0]          max_g_q, max_g_d;
  logic [7:0]          max_b_q, max_b_d;
  logic [7:0]          ar_q, ar_d;
  logic [7:0]          ag_q, ag_d;
  logic [7:0]          ab_q, ab_d;
  logic                a_valid_q, a_valid_d;
  logic                a_update_q, a_update_d;
  logic [7:0]          dark_q;
  logic                dark_valid_q;

  logic [7:0]          min_rg;
  logic [7:0]          pix_dark;
  logic                sof_accept;
  logic                use_smooth;
  logic [C_CNT_W-1:0]  cnt_inc;

  // (3*A_old + m + 2) >> 2; worst case 1022 fits the 10-bit sum and the
  // shifted result never exceeds 255.
  function automatic logic [7:0] smooth(input logic [7:0] a_old, input logic [7:0] m);
    logic [9:0] acc;
    acc = ({2'b00, a_old} << 1) + {2'b00, a_old} + {2'b00, m} + 10'd2;
    return 8'(acc >> 2);
  endfunction

  assign min_rg     = (bus.pix_r < bus.pix_g) ? bus.pix_r : bus.pix_g;
  assign pix_dark   = (min_rg < bus.pix_b) ? min_rg : bus.pix_b;
  assign sof_accept = bus.pix_valid & bus.pix_sof;
  assign use_smooth = SMOOTH_EN & a_valid_q;
  assign cnt_inc    = cnt_q + C_CNT_W'(1);

  // Frame FSM next state, running maximum and A computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    max_dark_d = max_dark_q;
    max_r_d    = max_r_q;
    max_g_d    = max_g_q;
    max_b_d    = max_b_q;
    ar_d       = ar_q;
    ag_d       = ag_q;
    ab_d       = ab_q;
    a_valid_d  = a_valid_q;
    a_update_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sof_accept) begin
          cnt_d      = C_CNT_W'(1);
          max_dark_d = pix_dark;
          max_r_d    = bus.pix_r;
          max_g_d    = bus.pix_g;
          max_b_d    = bus.pix_b;
          state_d    = C_AFTER_SOF;
        end
      end

      S_ACCUM: begin
        if (bus.pix_valid) begin
          if (bus.pix_sof) begin
            // Restart: the partial frame is dropped without publishing.
            cnt_d      = C_CNT_W'(1);
            max_dark_d = pix_dark;
            max_r_d    = bus.pix_r;
            max_g_d    = bus.pix_g;
            max_b_d    = bus.pix_b;
            state_d    = C_AFTER_SOF;
          end else begin
            cnt_d = cnt_inc;
            // Strict compare keeps the earliest pixel on ties.
            if (pix_dark > max_dark_q) begin
              max_dark_d = pix_dark;
              max_r_d    = bus.pix_r;
              max_g_d    = bus.pix_g;
              max_b_d    = bus.pix_b;
            end
            if (cnt_inc == C_NPIX_CNT) begin
              state_d = S_UPDATE;
            end
          end
        end
      end

      S_UPDATE: begin
        a_update_d = 1'b1;
        a_valid_d  = 1'b1;
        if (use_smooth) begin
          ar_d = smooth(ar_q, max_r_q);
          ag_d = smooth(ag_q, max_g_q);
          ab_d = smooth(ab_q, max_b_q);
        end else begin
          ar_d = max_r_q;
          ag_d = max_g_q;
          ab_d = max_b_q;
        end
        // The old maximum is consumed above before being overwritten here.
        if (sof_accept) begin
          cnt_d      = C_CNT_W'(1);
          max_dark_d = pix_dark;
          max_r_d    = bus.pix_r;
          max_g_d    = bus.pix_g;
          max_b_d    = bus.pix_b;
          state_d    = C_AFTER_SOF;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Frame state, maximum tracker and published A registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      max_dark_q <= 8'd0;
      max_r_q    <= 8'd0;
      max_g_q    <= 8'd0;
      max_b_q    <= 8'd0;
      ar_q       <= 8'hFF;
      ag_q       <= 8'hFF;
      ab_q       <= 8'hFF;
      a_valid_q  <= 1'b0;
      a_update_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      max_dark_q <= max_dark_d;
      max_r_q    <= max_r_d;
      max_g_q    <= max_g_d;
      max_b_q    <= max_b_d;
      ar_q       <= ar_d;
      ag_q       <= ag_d;
      ab_q       <= ab_d;
      a_valid_q  <= a_valid_d;
      a_update_q <= a_update_d;
    end
  end

  // Registered dark channel, independent of frame state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dark_q       <= 8'd0;
      dark_valid_q <= 1'b0;
    end else begin
      dark_valid_q <= bus.pix_valid;
      if (bus.pix_valid) begin
        dark_q <= pix_dark;
      end
    end
  end

  assign bus.dark_out   = dark_q;
  assign bus.dark_valid = dark_valid_q;
  assign bus.AR_global  = ar_q;
  assign bus.AG_global  = ag_q;
  assign bus.AB_global  = ab_q;
  assign bus.a_valid    = a_valid_q;
  assign bus.a_update   = a_update_q;

endmodule
`default_nettype wire

// File: tb/tb_global_ale_estimator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_global_ale_estimator
//  Description : Directed self-checking bench for global_ale_estimator
//                (IMG_W=4, IMG_H=2, SMOOTH_EN=1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_global_ale_estimator;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   upd_cnt;
  int   base;

  global_ale_estimator_if bus();

  global_ale_estimator #(
    .IMG_W    (4),
    .IMG_H    (2),
    .SMOOTH_EN(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       v;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] exp_dark;
    logic       exp_dv;
  } dark_vec_t;

  dark_vec_t dvec [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts a_update pulses; sampled on the active edge so it sees the pre-edge value.
  always @(posedge clk) begin
    if (bus.a_update === 1'b1) upd_cnt <= upd_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_px(input logic v, input logic s, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b);
    bus.pix_valid = v;
    bus.pix_sof   = s;
    bus.pix_r     = r;
    bus.pix_g     = g;
    bus.pix_b     = b;
  endtask

  task automatic px(input logic s, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk);
    set_px(1'b1, s, r, g, b);
  endtask

  task automatic idle();
    @(negedge clk);
    set_px(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_px(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] a_rgb();
    return {8'h00, bus.AR_global, bus.AG_global, bus.AB_global};
  endfunction

  initial begin
    errors  = 0;
    checks  = 0;
    upd_cnt = 0;
    rst_n   = 1'b0;
    set_px(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    dvec[0] = '{1'b1, 8'd50,  8'd40,  8'd60,  8'd40,  1'b1};
    dvec[1] = '{1'b0, 8'd0,   8'd0,   8'd0,   8'd40,  1'b0};
    dvec[2] = '{1'b0, 8'd99,  8'd99,  8'd99,  8'd40,  1'b0};
    dvec[3] = '{1'b1, 8'd7,   8'd200, 8'd9,   8'd7,   1'b1};
    dvec[4] = '{1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1};
    dvec[5] = '{1'b0, 8'd1,   8'd1,   8'd1,   8'd255, 1'b0};
    dvec[6] = '{1'b1, 8'd30,  8'd30,  8'd5,   8'd5,   1'b1};
    dvec[7] = '{1'b1, 8'd0,   8'd255, 8'd255, 8'd0,   1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_A", a_rgb(), 32'h00FFFFFF);
    chk("reset_a_valid", {31'd0, bus.a_valid}, 32'd0);
    chk("reset_a_update", {31'd0, bus.a_update}, 32'd0);
    chk("reset_dark_out", {24'd0, bus.dark_out}, 32'd0);
    chk("reset_dark_valid", {31'd0, bus.dark_valid}, 32'd0);
    rst_n = 1'b1;

    // 1: first frame, peak at idx5
    for (int i = 0; i < 8; i++) begin
      if (i == 5) px(1'b0, 8'd200, 8'd180, 8'd190);
      else        px(i == 0, 8'd10, 8'd20, 8'd30);
    end
    idle();
    chk("t1_update_early", {31'd0, bus.a_update}, 32'd0);
    idle();
    chk("t1_update_pulse", {31'd0, bus.a_update}, 32'd1);
    chk("t1_A", a_rgb(), {8'h00, 8'd200, 8'd180, 8'd190});
    chk("t1_a_valid", {31'd0, bus.a_valid}, 32'd1);
    idle();
    chk("t1_update_end", {31'd0, bus.a_update}, 32'd0);

    // 2: smoothed second frame
    for (int i = 0; i < 8; i++) px(i == 0, 8'd100, 8'd100, 8'd100);
    idle();
    idle();
    chk("t2_update_pulse", {31'd0, bus.a_update}, 32'd1);
    chk("t2_A", a_rgb(), {8'h00, 8'd175, 8'd160, 8'd168});

    // 3: tie keeps the earliest pixel, first frame after reset
    do_reset();
    chk("t3_reset_A", a_rgb(), 32'h00FFFFFF);
    chk("t3_reset_a_valid", {31'd0, bus.a_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2)      px(1'b0, 8'd150, 8'd160, 8'd170);
      else if (i == 6) px(1'b0, 8'd170, 8'd150, 8'd160);
      else             px(i == 0, 8'd10, 8'd20, 8'd30);
    end
    idle();
    idle();
    chk("t3_A", a_rgb(), {8'h00, 8'd150, 8'd160, 8'd170});
    chk("t3_a_valid", {31'd0, bus.a_valid}, 32'd1);

    // 4: sof at idx4 aborts the frame; publish comes 8 pixels after it
    idle();
    base = upd_cnt;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) px(1'b0, 8'd240, 8'd240, 8'd240);
      else        px(i == 0, 8'd10, 8'd20, 8'd30);
    end
    for (int j = 0; j < 4; j++) px(j == 0, 8'd10, 8'd20, 8'd30);
    idle();
    idle();
    idle();
    chk("t4_no_update_count", upd_cnt, base);
    chk("t4_A_unchanged", a_rgb(), {8'h00, 8'd150, 8'd160, 8'd170});
    for (int j = 4; j < 8; j++) px(1'b0, 8'd10, 8'd20, 8'd30);
    idle();
    idle();
    chk("t4_update_pulse", {31'd0, bus.a_update}, 32'd1);
    idle();
    chk("t4_update_count", upd_cnt, base + 1);
    chk("t4_A", a_rgb(), {8'h00, 8'd115, 8'd125, 8'd135});

    // 5: asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) px(i == 0, 8'd200, 8'd200, 8'd200);
    @(negedge clk);
    set_px(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_A", a_rgb(), 32'h00FFFFFF);
    chk("t5_async_a_valid", {31'd0, bus.a_valid}, 32'd0);
    chk("t5_async_dark_valid", {31'd0, bus.dark_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = upd_cnt;
    for (int i = 0; i < 10; i++) px(1'b0, 8'd220, 8'd220, 8'd220);
    idle();
    idle();
    idle();
    chk("t5_no_update_count", upd_cnt, base);
    chk("t5_A_still_reset", a_rgb(), 32'h00FFFFFF);
    chk("t5_a_valid_low", {31'd0, bus.a_valid}, 32'd0);

    // 6: dark path table, one-cycle latency with gaps in pix_valid
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_px(dvec[i].v, 1'b0, dvec[i].r, dvec[i].g, dvec[i].b);
      @(posedge clk);
      #1;
      chk($sformatf("t6_dark_%0d", i), {24'd0, bus.dark_out}, {24'd0, dvec[i].exp_dark});
      chk($sformatf("t6_dv_%0d", i), {31'd0, bus.dark_valid}, {31'd0, dvec[i].exp_dv});
    end
    idle();

    // 7: next frame's sof arrives in the UPDATE cycle
    chk("t7_start_a_valid", {31'd0, bus.a_valid}, 32'd0);
    base = upd_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) px(1'b0, 8'd90, 8'd80, 8'd70);
      else        px(i == 0, 8'd10, 8'd20, 8'd30);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("t7_f1_update_pulse", {31'd0, bus.a_update}, 32'd1);
        chk("t7_f1_A", a_rgb(), {8'h00, 8'd90, 8'd80, 8'd70});
        chk("t7_f1_a_valid", {31'd0, bus.a_valid}, 32'd1);
      end
      if (i == 2) chk("t7_f1_update_end", {31'd0, bus.a_update}, 32'd0);
      if (i == 7) set_px(1'b1, 1'b0, 8'd20, 8'd200, 8'd220);
      else        set_px(1'b1, i == 0, 8'd60, 8'd60, 8'd60);
    end
    idle();
    idle();
    chk("t7_f2_update_pulse", {31'd0, bus.a_update}, 32'd1);
    chk("t7_f2_A", a_rgb(), {8'h00, 8'd83, 8'd75, 8'd68});
    idle();
    chk("t7_update_count", upd_cnt, base + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
